// File: rtl/boneless_ext_timer.sv
// boneless_ext_timer: programmable down-counting timer on the Boneless external bus.
// Decodes a 4-word window at BASE (CTRL, RELOAD, COUNT, STATUS), returns read data
// one cycle after the read strobe (zero when not selected) and raises irq on expiry.
module boneless_ext_timer #(
    parameter logic [15:0] BASE         = 16'h0000,
    parameter logic [15:0] RESET_RELOAD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ext_adr,
    input  logic        ext_re,
    input  logic        ext_we,
    input  logic [15:0] ext_dat_w,
    output logic [15:0] ext_dat_r,
    output logic        irq
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_mode;
    logic        r_irq_en;
    logic [7:0]  r_psc;
    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic        r_pend;
    logic [7:0]  r_prescaler;
    logic [15:0] r_dat_r;
    logic        r_irq;

    logic        w_sel;
    logic [1:0]  w_idx;
    logic        w_wr_ctrl;
    logic        w_wr_reload;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_running;
    logic        w_tick;
    logic        w_expiry;
    logic        w_pend_next;
    logic        w_irq_en_next;
    logic [15:0] w_rd_data;

    // Address decode and write strobes per register
    always_comb begin
        w_sel       = (ext_adr[15:2] == BASE[15:2]);
        w_idx       = ext_adr[1:0];
        w_wr_ctrl   = ext_we && w_sel && (w_idx == 2'd0);
        w_wr_reload = ext_we && w_sel && (w_idx == 2'd1);
        w_wr_count  = ext_we && w_sel && (w_idx == 2'd2);
        w_wr_status = ext_we && w_sel && (w_idx == 2'd3);
    end

    // State register: EN bit of CTRL is the run state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: CTRL write takes priority, one-shot expiry stops the timer
    always_comb begin
        w_state_next = r_state;
        if (w_wr_ctrl) begin
            w_state_next = ext_dat_w[0] ? ST_RUNNING : ST_STOPPED;
        end else if (w_expiry && !r_mode) begin
            w_state_next = ST_STOPPED;
        end
    end

    // State outputs: tick and expiry qualifiers (a COUNT write suppresses expiry)
    always_comb begin
        w_running = (r_state == ST_RUNNING);
        w_tick    = w_running && (r_prescaler == r_psc);
        w_expiry  = w_tick && !w_wr_count && (r_count == 16'h0000);
    end

    // Next PEND / IRQ_EN, shared by PEND and the registered irq (set beats clear)
    always_comb begin
        w_pend_next = r_pend;
        if (w_expiry) begin
            w_pend_next = 1'b1;
        end else if (w_wr_status && ext_dat_w[0]) begin
            w_pend_next = 1'b0;
        end
        w_irq_en_next = w_wr_ctrl ? ext_dat_w[2] : r_irq_en;
    end

    // CTRL fields other than EN, and RELOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= 1'b0;
            r_irq_en <= 1'b0;
            r_psc    <= '0;
            r_reload <= RESET_RELOAD;
        end else begin
            if (w_wr_ctrl) begin
                r_mode   <= ext_dat_w[1];
                r_irq_en <= ext_dat_w[2];
                r_psc    <= ext_dat_w[15:8];
            end
            if (w_wr_reload) begin
                r_reload <= ext_dat_w;
            end
        end
    end

    // Prescaler: cleared on EN 0->1, wraps on tick, frozen while stopped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescaler <= '0;
        end else if (w_wr_ctrl && ext_dat_w[0] && !w_running) begin
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
        end else if (w_running) begin
            r_prescaler <= r_prescaler + 8'd1;
        end
    end

    // Counter: bus write wins over tick; expiry reloads (periodic) or holds at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= ext_dat_w;
        end else if (w_tick) begin
            if (r_count != 16'h0000) begin
                r_count <= r_count - 16'd1;
            end else if (r_mode) begin
                r_count <= r_reload;
            end
        end
    end

    // Pending flag and registered interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_irq  <= w_pend_next & w_irq_en_next;
        end
    end

    // Read mux over pre-edge register values
    always_comb begin
        w_rd_data = '0;
        case (w_idx)
            2'd0:    w_rd_data = {r_psc, 5'b00000, r_irq_en, r_mode, w_running};
            2'd1:    w_rd_data = r_reload;
            2'd2:    w_rd_data = r_count;
            default: w_rd_data = {15'h0000, r_pend};
        endcase
    end

    // Registered read data, zero unless a selected read happened last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat_r <= '0;
        end else begin
            r_dat_r <= (ext_re && w_sel) ? w_rd_data : 16'h0000;
        end
    end

    assign ext_dat_r = r_dat_r;
    assign irq       = r_irq;

endmodule

// File: tb/tb_boneless_ext_timer.sv
// Directed testbench for boneless_ext_timer with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_boneless_ext_timer;

    localparam logic [15:0] A_CTRL   = 16'h0040;
    localparam logic [15:0] A_RELOAD = 16'h0041;
    localparam logic [15:0] A_COUNT  = 16'h0042;
    localparam logic [15:0] A_STATUS = 16'h0043;
    localparam logic [15:0] A_UNSEL  = 16'h0044;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ext_adr;
    logic        ext_re;
    logic        ext_we;
    logic [15:0] ext_dat_w;
    logic [15:0] ext_dat_r;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] d;
    logic [15:0] exp_os [6];

    boneless_ext_timer #(
        .BASE        (16'h0040),
        .RESET_RELOAD(16'hFFFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ext_adr  (ext_adr),
        .ext_re   (ext_re),
        .ext_we   (ext_we),
        .ext_dat_w(ext_dat_w),
        .ext_dat_r(ext_dat_r),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; occupies exactly one rising edge
    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        ext_adr = a; ext_dat_w = v; ext_we = 1'b1; ext_re = 1'b0;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        ext_adr = a; ext_re = 1'b1; ext_we = 1'b0;
        @(negedge clk);
        ext_re = 1'b0;
        v = ext_dat_r;
    endtask

    task automatic rdwr(input logic [15:0] a, input logic [15:0] wv, output logic [15:0] v);
        ext_adr = a; ext_dat_w = wv; ext_re = 1'b1; ext_we = 1'b1;
        @(negedge clk);
        ext_re = 1'b0; ext_we = 1'b0;
        v = ext_dat_r;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ext_adr = '0; ext_re = 1'b0; ext_we = 1'b0; ext_dat_w = '0;
        repeat (3) @(negedge clk);
        check("rst_dat_r", ext_dat_r, 16'h0000);
        check("rst_irq", {15'h0, irq}, 16'h0000);
        rst = 1'b0;

        // Reset values and select decoding
        rd(A_CTRL, d);   check("rst_ctrl", d, 16'h0000);
        rd(A_COUNT, d);  check("rst_count", d, 16'h0000);
        rd(A_STATUS, d); check("rst_status", d, 16'h0000);
        rd(A_RELOAD, d); check("rst_reload", d, 16'hFFFF);
        @(negedge clk);  check("rd_return_zero", ext_dat_r, 16'h0000);
        rd(A_UNSEL, d);  check("unsel_read", d, 16'h0000);
        wr(A_CTRL, 16'hABF8);
        rd(A_CTRL, d);   check("ctrl_reserved", d, 16'hAB00);
        wr(A_CTRL, 16'h0000);

        // Periodic, PSC=0, RELOAD=3
        wr(A_RELOAD, 16'd3);
        wr(A_COUNT, 16'd3);
        wr(A_CTRL, 16'h0007);
        rd(A_COUNT, d); check("per_cnt3", d, 16'd3);
        rd(A_COUNT, d); check("per_cnt2", d, 16'd2);
        rd(A_COUNT, d); check("per_cnt1", d, 16'd1);
        check("per_irq_before", {15'h0, irq}, 16'h0000);
        rd(A_COUNT, d); check("per_cnt0", d, 16'd0);
        check("per_irq_expiry", {15'h0, irq}, 16'h0001);
        rd(A_COUNT, d); check("per_reload", d, 16'd3);
        rd(A_STATUS, d); check("per_pend", d, 16'h0001);
        wr(A_STATUS, 16'h0001);
        check("per_irq_clr", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        check("per_irq_next", {15'h0, irq}, 16'h0001);
        wr(A_CTRL, 16'h0000);
        wr(A_STATUS, 16'h0001);

        // One-shot, PSC=2, COUNT=1
        exp_os[0] = 16'd1; exp_os[1] = 16'd1; exp_os[2] = 16'd1;
        exp_os[3] = 16'd0; exp_os[4] = 16'd0; exp_os[5] = 16'd0;
        wr(A_COUNT, 16'd1);
        wr(A_CTRL, 16'h0201);
        for (int i = 0; i < 6; i++) begin
            rd(A_COUNT, d); check($sformatf("os_cnt%0d", i), d, exp_os[i]);
        end
        rd(A_STATUS, d); check("os_pend", d, 16'h0001);
        rd(A_CTRL, d);   check("os_stopped", d, 16'h0200);
        rd(A_COUNT, d);  check("os_cnt_hold", d, 16'h0000);
        check("os_irq_masked", {15'h0, irq}, 16'h0000);
        wr(A_STATUS, 16'h0001);
        repeat (6) @(negedge clk);
        rd(A_STATUS, d); check("os_no_repend", d, 16'h0000);

        // STATUS clear on the expiry cycle: set wins
        wr(A_RELOAD, 16'd3);
        wr(A_COUNT, 16'd1);
        wr(A_CTRL, 16'h0007);
        @(negedge clk);
        wr(A_STATUS, 16'h0001);
        rd(A_STATUS, d); check("clr_vs_set", d, 16'h0001);
        wr(A_CTRL, 16'h0004);
        wr(A_STATUS, 16'h0000);
        rd(A_STATUS, d); check("status_w0", d, 16'h0001);
        check("irq_held", {15'h0, irq}, 16'h0001);
        wr(A_STATUS, 16'h0001);
        check("irq_drop", {15'h0, irq}, 16'h0000);
        rd(A_STATUS, d); check("status_clr", d, 16'h0000);

        // COUNT write on a tick cycle; read+write same cycle
        wr(A_COUNT, 16'h1000);
        wr(A_CTRL, 16'h0001);
        wr(A_COUNT, 16'h1234);
        rd(A_COUNT, d); check("cnt_wr_wins", d, 16'h1234);
        rd(A_COUNT, d); check("cnt_dec", d, 16'h1233);
        rdwr(A_COUNT, 16'h5555, d); check("rdwr_old", d, 16'h1232);
        rd(A_COUNT, d); check("rdwr_new", d, 16'h5555);

        // Async reset while running, PEND=1, read in flight (RELOAD=0 expires every tick)
        wr(A_RELOAD, 16'd0);
        wr(A_COUNT, 16'd0);
        wr(A_CTRL, 16'h0007);
        wr(A_STATUS, 16'h0001);
        ext_adr = A_CTRL; ext_re = 1'b1;
        @(posedge clk);
        #2;
        check("inflight_dat", ext_dat_r, 16'h0007);
        check("inflight_irq", {15'h0, irq}, 16'h0001);
        rst = 1'b1;
        #1;
        check("async_dat_r", ext_dat_r, 16'h0000);
        check("async_irq", {15'h0, irq}, 16'h0000);
        ext_re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(A_CTRL, d);   check("post_rst_ctrl", d, 16'h0000);
        rd(A_RELOAD, d); check("post_rst_reload", d, 16'hFFFF);
        rd(A_COUNT, d);  check("post_rst_count", d, 16'h0000);
        rd(A_STATUS, d); check("post_rst_status", d, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
